funcmap_replay_buf: RTL and testbench

- Ordered record/replay buffer for uninterpreted-function results in refinement-check wrappers.
- Record side (implementation) captures each function-call result in the order the RTL produces it.
- Replay side (ILA-model instance) reads those same values in the same order, so both sides observe identical nondet results.
- Sits in the wrapper between the implementation and the generated ILA module. It replaces per-result hold registers when the call count varies per instruction.

---
 rtl/funcmap_pkg.sv | 11 +
 rtl/funcmap_replay_buf_if.sv | 38 +++
 rtl/funcmap_store.sv | 20 ++
 rtl/funcmap_replay_buf.sv | 98 +++++++++
 tb/tb_funcmap_replay_buf.sv | 139 +++++++++++++
 5 files changed

// File: rtl/funcmap_pkg.sv
// funcmap_pkg: shared state encoding and default sizing for the funcmap replay buffer
package funcmap_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        REPLAY = 2'd2,
        DONE   = 2'd3
    } funcmap_state_e;
    localparam int FUNCMAP_W     = 8;
    localparam int FUNCMAP_DEPTH = 4;
endpackage

// File: rtl/funcmap_replay_buf_if.sv
// funcmap_replay_buf_if: record/replay handshake bundle; FUNCMAP_REPLAY_ASSERT_EN adds property outputs
interface funcmap_replay_buf_if #(
    parameter int W     = funcmap_pkg::FUNCMAP_W,
    parameter int DEPTH = funcmap_pkg::FUNCMAP_DEPTH
);
    localparam int AW = $clog2(DEPTH);
    logic          start;
    logic          rec_valid;
    logic [W-1:0]  rec_data;
    logic          rec_ready;
    logic          rec_done;
    logic          rep_req;
    logic [W-1:0]  rep_data;
    logic          rep_valid;
    logic          rep_end;
    logic [AW:0]   count;
    logic [1:0]    state;
    logic          overflow;
    logic          underflow;
`ifdef FUNCMAP_REPLAY_ASSERT_EN
    logic          replay_ok;
    logic [AW:0]   replay_mismatch_cnt;
`endif
    modport master (
        output start, rec_valid, rec_data, rec_done, rep_req, rep_end,
`ifdef FUNCMAP_REPLAY_ASSERT_EN
        input  replay_ok, replay_mismatch_cnt,
`endif
        input  rec_ready, rep_data, rep_valid, count, state, overflow, underflow
    );
    modport slave (
        input  start, rec_valid, rec_data, rec_done, rep_req, rep_end,
`ifdef FUNCMAP_REPLAY_ASSERT_EN
        output replay_ok, replay_mismatch_cnt,
`endif
        output rec_ready, rep_data, rep_valid, count, state, overflow, underflow
    );
endinterface

// File: rtl/funcmap_store.sv
// funcmap_store: unreset DEPTH x W register array, synchronous write, combinational read
module funcmap_store #(
    parameter int W       = 8,
    parameter int DEPTH   = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [DEPTH];
    // write port; contents deliberately not reset
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end
    assign rdata = mem_q[raddr];
endmodule

// File: rtl/funcmap_replay_buf.sv
// funcmap_replay_buf: ordered record/replay buffer for uninterpreted-function results; optional FUNCMAP_REPLAY_ASSERT_EN
module funcmap_replay_buf
    import funcmap_pkg::*;
#(
    parameter int W       = FUNCMAP_W,
    parameter int DEPTH   = FUNCMAP_DEPTH,
    localparam int AW     = $clog2(DEPTH),
    localparam int PW     = AW + 1
) (
    input  logic clk,
    input  logic rst,
    funcmap_replay_buf_if.slave bus
);
    funcmap_state_e state_q, state_d;
    logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic           overflow_q, overflow_d, underflow_q, underflow_d;
    logic           rec_ready, rep_valid, we;
    logic [W-1:0]   rd_data;
`ifdef FUNCMAP_REPLAY_ASSERT_EN
    logic [PW-1:0]  mis_q, mis_d;
`endif
    assign rec_ready = (state_q == RECORD) && (wptr_q != PW'(DEPTH));
    assign rep_valid = (state_q == REPLAY) && (rptr_q != wptr_q);
    assign we        = ~bus.start & bus.rec_valid & rec_ready;
    funcmap_store #(.W(W), .DEPTH(DEPTH)) u_store (
        .clk   (clk),
        .we    (we),
        .waddr (wptr_q[AW-1:0]),
        .wdata (bus.rec_data),
        .raddr (rptr_q[AW-1:0]),
        .rdata (rd_data)
    );
    // next state, pointers and sticky flags; start overrides everything
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
`ifdef FUNCMAP_REPLAY_ASSERT_EN
        mis_d       = mis_q;
`endif
        if (bus.start) begin
            state_d     = RECORD;
            wptr_d      = '0;
            rptr_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
`ifdef FUNCMAP_REPLAY_ASSERT_EN
            mis_d       = '0;
`endif
        end else if (state_q == RECORD) begin
            wptr_d     = (bus.rec_valid & rec_ready) ? wptr_q + 1'b1 : wptr_q;
            overflow_d = overflow_q | (bus.rec_valid & ~rec_ready);
            state_d    = bus.rec_done ? REPLAY : RECORD;
        end else if (state_q == REPLAY) begin
            rptr_d      = (bus.rep_req & rep_valid) ? rptr_q + 1'b1 : rptr_q;
            underflow_d = underflow_q | (bus.rep_req & ~rep_valid);
`ifdef FUNCMAP_REPLAY_ASSERT_EN
            mis_d       = (bus.rep_req & ~rep_valid & (mis_q != '1)) ? mis_q + 1'b1 : mis_q;
`endif
            state_d     = bus.rep_end ? DONE : REPLAY;
        end
    end
    // state register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`ifdef FUNCMAP_REPLAY_ASSERT_EN
            mis_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
`ifdef FUNCMAP_REPLAY_ASSERT_EN
            mis_q       <= mis_d;
`endif
        end
    end
    assign bus.rec_ready = rec_ready;
    assign bus.rep_valid = rep_valid;
    assign bus.rep_data  = rep_valid ? rd_data : '0;
    assign bus.count     = wptr_q - rptr_q;
    assign bus.state     = state_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`ifdef FUNCMAP_REPLAY_ASSERT_EN
    assign bus.replay_ok           = (state_q != DONE) | (~overflow_q & ~underflow_q & (rptr_q == wptr_q));
    assign bus.replay_mismatch_cnt = mis_q;
`endif
endmodule

// File: tb/tb_funcmap_replay_buf.sv
// tb_funcmap_replay_buf: directed checks of record/replay ordering, overflow/underflow, start and async reset
module tb_funcmap_replay_buf;
    logic clk, rst;
    int checks = 0;
    int failures = 0;
    funcmap_replay_buf_if #(.W(8), .DEPTH(4)) bus ();
    funcmap_replay_buf #(.W(8), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst = 1'b1;
        bus.start = 0; bus.rec_valid = 0; bus.rec_data = 0; bus.rec_done = 0;
        bus.rep_req = 0; bus.rep_end = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_state", bus.state, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_rec_ready", bus.rec_ready, 0);
        chk("rst_rep_valid", bus.rep_valid, 0);
        chk("rst_rep_data", bus.rep_data, 0);
        chk("rst_flags", {bus.overflow, bus.underflow}, 0);
        // basic record 11,22,33 then replay
        bus.start = 1; tick(); bus.start = 0;
        chk("t1_state_rec", bus.state, 1);
        chk("t1_ready", bus.rec_ready, 1);
        bus.rec_valid = 1; bus.rec_data = 8'h11; tick();
        chk("t1_count1", bus.count, 1);
        bus.rec_data = 8'h22; tick();
        bus.rec_data = 8'h33; tick();
        bus.rec_valid = 0; bus.rec_done = 1; tick(); bus.rec_done = 0;
        chk("t1_state_rep", bus.state, 2);
        chk("t1_count3", bus.count, 3);
        chk("t1_data0", bus.rep_data, 8'h11);
        bus.rep_req = 1; tick();
        chk("t1_data1", bus.rep_data, 8'h22);
        chk("t1_count2", bus.count, 2);
        tick();
        chk("t1_data2", bus.rep_data, 8'h33);
        chk("t1_countb1", bus.count, 1);
        tick(); bus.rep_req = 0;
        chk("t1_count0", bus.count, 0);
        chk("t1_valid0", bus.rep_valid, 0);
        bus.rep_end = 1; tick(); bus.rep_end = 0;
        chk("t1_done", bus.state, 3);
        chk("t1_flags", {bus.overflow, bus.underflow}, 0);
`ifdef FUNCMAP_REPLAY_ASSERT_EN
        chk("t1_ok", bus.replay_ok, 1);
`endif
        // overflow with five writes into DEPTH=4
        bus.start = 1; tick(); bus.start = 0;
        bus.rec_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            bus.rec_data = 8'(i); tick();
        end
        chk("t2_ready_full", bus.rec_ready, 0);
        chk("t2_ovf_pre", bus.overflow, 0);
        bus.rec_data = 8'h05; tick(); bus.rec_valid = 0;
        chk("t2_ovf", bus.overflow, 1);
        chk("t2_count4", bus.count, 4);
        bus.rec_done = 1; tick(); bus.rec_done = 0;
        for (int i = 1; i <= 4; i++) begin
            chk("t2_replay", bus.rep_data, i);
            bus.rep_req = 1; tick(); bus.rep_req = 0;
        end
        chk("t2_drained", bus.rep_valid, 0);
        bus.rep_end = 1; tick(); bus.rep_end = 0;
        chk("t2_done", bus.state, 3);
        chk("t2_ovf_hold", bus.overflow, 1);
`ifdef FUNCMAP_REPLAY_ASSERT_EN
        chk("t2_ok", bus.replay_ok, 0);
`endif
        // underflow on second read
        bus.start = 1; tick(); bus.start = 0;
        chk("t3_ovf_clr", bus.overflow, 0);
        bus.rec_valid = 1; bus.rec_data = 8'hA5; tick(); bus.rec_valid = 0;
        bus.rec_done = 1; tick(); bus.rec_done = 0;
        chk("t3_data", bus.rep_data, 8'hA5);
        bus.rep_req = 1; tick();
        chk("t3_valid0", bus.rep_valid, 0);
        chk("t3_data0", bus.rep_data, 0);
        chk("t3_unf_pre", bus.underflow, 0);
        tick(); bus.rep_req = 0;
        chk("t3_unf", bus.underflow, 1);
        bus.rep_end = 1; tick(); bus.rep_end = 0;
        chk("t3_done", bus.state, 3);
`ifdef FUNCMAP_REPLAY_ASSERT_EN
        chk("t3_ok", bus.replay_ok, 0);
        chk("t3_miscnt", bus.replay_mismatch_cnt, 1);
`endif
        // write in same cycle as rec_done
        bus.start = 1; tick(); bus.start = 0;
        chk("t4_unf_clr", bus.underflow, 0);
        bus.rec_valid = 1; bus.rec_data = 8'h7E; bus.rec_done = 1; tick();
        bus.rec_valid = 0; bus.rec_done = 0;
        chk("t4_state", bus.state, 2);
        chk("t4_count", bus.count, 1);
        chk("t4_data", bus.rep_data, 8'h7E);
        // start mid-replay
        bus.start = 1; tick(); bus.start = 0;
        bus.rec_valid = 1; bus.rec_data = 8'h01; tick();
        bus.rec_data = 8'h02; tick(); bus.rec_valid = 0;
        bus.rec_done = 1; tick(); bus.rec_done = 0;
        chk("t5_count2", bus.count, 2);
        chk("t5_rep", bus.state, 2);
        bus.start = 1; bus.rep_req = 1; tick(); bus.start = 0; bus.rep_req = 0;
        chk("t5_restart", bus.state, 1);
        chk("t5_count0", bus.count, 0);
        chk("t5_unf", bus.underflow, 0);
        bus.rec_valid = 1; bus.rec_data = 8'h09; tick(); bus.rec_valid = 0;
        bus.rec_done = 1; tick(); bus.rec_done = 0;
        chk("t5_data", bus.rep_data, 8'h09);
        // asynchronous reset between edges
        bus.start = 1; tick(); bus.start = 0;
        bus.rec_valid = 1; bus.rec_data = 8'h44; tick();
        bus.rec_data = 8'h55; tick(); bus.rec_valid = 0;
        chk("t6_count2", bus.count, 2);
        chk("t6_state_rec", bus.state, 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_state", bus.state, 0);
        chk("t6_count", bus.count, 0);
        chk("t6_ready", bus.rec_ready, 0);
        rst = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
